// File: rtl/serial_adder.sv
// Bit-serial adder: two operands are streamed LSB-first through one fulladder cell,
// one bit per clock, with the carry held in a register between bits.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic z,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ z;
   assign carry = (a & b) | (z & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_aSh;
   logic [WIDTH-1:0] r_bSh;
   logic [WIDTH-1:0] r_sSh;
   logic [WIDTH-1:0] r_sum;
   logic             r_cQ;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;

   logic             w_faSum;
   logic             w_faCarry;
   logic [WIDTH-1:0] w_sNext;

   fulladder u_fa (
      .a     (r_aSh[0]),
      .b     (r_bSh[0]),
      .z     (r_cQ),
      .sum   (w_faSum),
      .carry (w_faCarry)
   );

   // New sum bit enters at the MSB so the word lines up after WIDTH shifts.
   assign w_sNext = (r_sSh >> 1) | (WIDTH'(w_faSum) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_aSh   <= '0;
         r_bSh   <= '0;
         r_sSh   <= '0;
         r_sum   <= '0;
         r_cQ    <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_aSh   <= a;
                  r_bSh   <= b;
                  r_cQ    <= cin;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_cQ  <= w_faCarry;
               r_sSh <= w_sNext;
               r_aSh <= r_aSh >> 1;
               r_bSh <= r_bSh >> 1;
               // The output register is only written once the whole word is assembled.
               if (r_cnt == LAST) begin
                  r_sum   <= w_sNext;
                  r_cout  <= w_faCarry;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit and a 1-bit instance driven with
// directed vectors; monitors pop expected results whenever done is seen.

module tb_serial_adder;

   typedef struct {
      logic [7:0] s;
      logic       c;
      int         t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;

   int   cyc         = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   busyRun8    = 0;
   int   busyRun1    = 0;

   exp_t q8[$];
   exp_t q1[$];

   // Hand-computed {cout,sum} for index {a,b,cin}.
   logic [1:0] tab1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expected);
      vectors++;
      if (act !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expected);
      end
   endtask

   // Monitor for the 8-bit instance: every done pulse must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         checkOutput("done8_expected", 32'(q8.size() > 0), 32'd1);
         if (q8.size() > 0) begin
            e = q8.pop_front();
            checkOutput("sum8", 32'(sum8), 32'(e.s));
            checkOutput("cout8", 32'(cout8), 32'(e.c));
            checkOutput("done8_cycle", 32'(cyc), 32'(e.t));
            checkOutput("busy8_cycles", 32'(busyRun8), 32'd8);
         end
         busyRun8 = 0;
      end else if (busy8) begin
         busyRun8++;
      end else begin
         busyRun8 = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         checkOutput("done1_expected", 32'(q1.size() > 0), 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("sum1", 32'(sum1), 32'(e.s));
            checkOutput("cout1", 32'(cout1), 32'(e.c));
            checkOutput("done1_cycle", 32'(cyc), 32'(e.t));
            checkOutput("busy1_cycles", 32'(busyRun1), 32'd1);
         end
         busyRun1 = 0;
      end else if (busy1) begin
         busyRun1++;
      end else begin
         busyRun1 = 0;
      end
   end

   task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                 input bit track, input logic [7:0] s, input logic c);
      int n = 0;
      while ((busy8 || done8) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle8_before_start", 32'(busy8 || done8), 32'd0);
      a8     = a;
      b8     = b;
      cin8   = cin;
      start8 = 1'b1;
      if (track) q8.push_back('{s, c, cyc + 1 + 8});
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic applyStimulus1(input logic a, input logic b, input logic cin,
                                 input logic s, input logic c);
      int n = 0;
      while ((busy1 || done1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle1_before_start", 32'(busy1 || done1), 32'd0);
      a1     = a;
      b1     = b;
      cin1   = cin;
      start1 = 1'b1;
      q1.push_back('{8'(s), c, cyc + 1 + 1});
      @(negedge clk);
      start1 = 1'b0;
   endtask

   initial begin
      int n;
      int n0;
      rst    = 1'b1;
      start8 = 1'b0;
      a8     = '0;
      b8     = '0;
      cin8   = 1'b0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      cin1   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      checkOutput("reset_busy8", 32'(busy8), 32'd0);
      checkOutput("reset_done8", 32'(done8), 32'd0);
      checkOutput("reset_sum8", 32'(sum8), 32'd0);
      checkOutput("reset_cout8", 32'(cout8), 32'd0);
      checkOutput("reset_busy1", 32'(busy1), 32'd0);
      checkOutput("reset_done1", 32'(done1), 32'd0);
      checkOutput("reset_sum1", 32'(sum1), 32'd0);
      checkOutput("reset_cout1", 32'(cout1), 32'd0);

      applyStimulus8(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0);
      applyStimulus8(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
      applyStimulus8(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);

      // start pulses during RUN and DONE must not disturb the result
      applyStimulus8(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0);
      repeat (2) @(negedge clk);
      a8     = 8'hAA;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ignored_done_seen", 32'(done8), 32'd1);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("ignored_idle_done", 32'(done8), 32'd0);
      checkOutput("ignored_idle_busy", 32'(busy8), 32'd0);
      checkOutput("ignored_hold_sum", 32'(sum8), 32'h30);
      @(negedge clk);
      checkOutput("ignored_still_idle", 32'(busy8), 32'd0);

      // reset four edges into RUN aborts with no done pulse
      applyStimulus8(8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_done", 32'(done8), 32'd0);
      checkOutput("abort_sum", 32'(sum8), 32'd0);
      checkOutput("abort_cout", 32'(cout8), 32'd0);
      repeat (12) @(negedge clk);
      applyStimulus8(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);

      // start held high: the second operation is accepted on the first IDLE edge
      n = 0;
      while ((busy8 || done8) && n < 50) begin
         @(negedge clk);
         n++;
      end
      n0     = cyc;
      a8     = 8'h03;
      b8     = 8'h04;
      cin8   = 1'b0;
      start8 = 1'b1;
      q8.push_back('{8'h07, 1'b0, n0 + 1 + 8});
      q8.push_back('{8'h00, 1'b1, n0 + 1 + 10 + 8});
      @(negedge clk);
      a8 = 8'h80;
      b8 = 8'h80;
      while (cyc < n0 + 11) @(negedge clk);
      start8 = 1'b0;

      for (int i = 0; i < 8; i++) begin
         applyStimulus1(i[2], i[1], i[0], tab1[i][0], tab1[i][1]);
      end

      n = 0;
      while ((q8.size() > 0 || q1.size() > 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checkOutput("queue8_drained", 32'(q8.size()), 32'd0);
      checkOutput("queue1_drained", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule
